// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_ENABLE    = 8'hF4;
    localparam logic [7:0] RESP_ACK      = 8'hFA;
    localparam int         FRAME_TX_BITS = 10;

    // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [FRAME_TX_BITS-1:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizer, glitch filter and falling-edge detector for one PS/2 line.
// The filtered level only changes after FILTER_LEN consecutive synchronized
// samples disagree with it, so line change to fall pulse is 2 + FILTER_LEN cycles.
module ps2_line_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic filt_out,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q, filt_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count how long the synchronized sample has disagreed with the filtered level.
    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Idle bus is high, so everything resets to 1 except the counter and pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_out = filt_q;
    assign fall     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked
// shifting of data/parity/stop and capture of the device acknowledge bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES     = 5000,
    parameter int FIRST_EDGE_TIMEOUT = 750000,
    parameter int BIT_TIMEOUT        = 10000,
    parameter int FILTER_LEN         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int TMR_MAX_A = (INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT;
    localparam int TMR_MAX   = (TMR_MAX_A > FIRST_EDGE_TIMEOUT) ? TMR_MAX_A : FIRST_EDGE_TIMEOUT;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam int BIT_CNT_W = $clog2(FRAME_TX_BITS + 1);

    ps2_tx_state_e                state_q, state_d;
    logic [TMR_W-1:0]             timer_q, timer_d;
    logic [BIT_CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_TX_BITS-1:0]     shift_q, shift_d;
    logic                         data_oe_q, data_oe_d;
    logic                         ack_flag_q, ack_flag_d;
    logic                         data_s1_q, data_s1_d;
    logic                         data_s2_q, data_s2_d;

    logic                         clk_filt;
    logic                         clk_fall;
    logic [TMR_W-1:0]             timer_inc;
    logic [TMR_W-1:0]             limit_m1;
    logic                         expired;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_sync (
        .clk      (clk),
        .rst      (rst),
        .line_in  (ps2_clk_in),
        .filt_out (clk_filt),
        .fall     (clk_fall)
    );

    // Saturating timer; the limit switches to the long first-edge window until the first fall.
    always_comb begin
        timer_inc = (timer_q == {TMR_W{1'b1}}) ? timer_q : timer_q + TMR_W'(1);
        limit_m1  = (state_q == SEND && bit_cnt_q == '0) ? TMR_W'(FIRST_EDGE_TIMEOUT - 1)
                                                         : TMR_W'(BIT_TIMEOUT - 1);
        expired   = (timer_q >= limit_m1);
    end

    // Next-state, datapath and output decode for the transmit FSM.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_inc;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_oe_d   = data_oe_q;
        ack_flag_d  = ack_flag_q;
        data_s1_d   = ps2_data_in;
        data_s2_d   = data_s1_q;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_ready    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        ack_ok      = 1'b0;
        err         = 1'b0;

        case (state_q)
            IDLE: begin
                tx_ready  = 1'b1;
                busy      = 1'b0;
                timer_d   = '0;
                bit_cnt_d = '0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d = ps2_tx_frame(tx_data);
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (timer_q >= TMR_W'(INHIBIT_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = RTS;
                end
            end
            RTS: begin
                // Start bit goes low while the clock is still held, then the clock is released.
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                timer_d     = '0;
                bit_cnt_d   = '0;
                data_oe_d   = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                ps2_data_oe = data_oe_q;
                if (clk_fall) begin
                    timer_d   = '0;
                    data_oe_d = ~shift_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(FRAME_TX_BITS - 1)) begin
                        state_d = ACK;
                    end
                end else if (expired) begin
                    state_d = ERR;
                end
            end
            ACK: begin
                data_oe_d = 1'b0;
                if (clk_fall) begin
                    ack_flag_d = ~data_s2_q;
                    timer_d    = '0;
                    state_d    = WAIT_IDLE;
                end else if (expired) begin
                    state_d = ERR;
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && data_s2_q) begin
                    state_d = DONE;
                end else if (expired) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                done      = 1'b1;
                ack_ok    = ack_flag_q;
                err       = ~ack_flag_q;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
            ERR: begin
                done      = 1'b1;
                err       = 1'b1;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset lands in IDLE with both lines released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_oe_q  <= 1'b0;
            ack_flag_q <= 1'b0;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_oe_q  <= data_oe_d;
            ack_flag_q <= ack_flag_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model (40-cycle clock).
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, ack_ok, err;

    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       glitch   = 1'b0;

    int checks   = 0;
    int failures = 0;

    int   cyc      = 0;
    int   inh_cnt  = 0;
    int   rts_cnt  = 0;
    int   rel_cnt  = 0;
    int   rel_cyc  = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic last_ack = 1'b0;
    logic last_err = 1'b0;
    logic [1:0] oe_at_done = 2'b00;
    logic prev_clk_oe = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (20),
        .FIRST_EDGE_TIMEOUT (200),
        .BIT_TIMEOUT        (100),
        .FILTER_LEN         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Open-drain bus: a line is low if either side pulls it.
    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk & ~glitch;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus observer: inhibit/RTS lengths, clock release and done pulses.
    always @(negedge clk) begin
        prev_clk_oe <= ps2_clk_oe;
        if (ps2_clk_oe && !ps2_data_oe) inh_cnt <= inh_cnt + 1;
        if (ps2_clk_oe && ps2_data_oe)  rts_cnt <= rts_cnt + 1;
        if (prev_clk_oe && !ps2_clk_oe) begin
            rel_cnt <= rel_cnt + 1;
            rel_cyc <= cyc;
        end
        if (done) begin
            done_cnt   <= done_cnt + 1;
            done_cyc   <= cyc;
            last_ack   <= ack_ok;
            last_err   <= err;
            oe_at_done <= {ps2_clk_oe, ps2_data_oe};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_release(input string tag, input int base);
        for (int i = 0; i < 100 && rel_cnt == base; i++) @(negedge clk);
        check_eq({tag, "_release"}, 32'(rel_cnt != base), 32'd1);
    endtask

    // Device clocks nfalls edges; bits[k-1] is the line level seen before the k-th rise.
    task automatic dev_frame(input int nfalls, input bit do_ack, input int glitch_fall,
                             output logic [9:0] bits);
        bits = '0;
        repeat (15) @(negedge clk);
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk = 1'b0;
            if (k == 11 && do_ack) dev_data = 1'b0;
            repeat (20) @(negedge clk);
            if (k <= 10) bits[k-1] = ~ps2_data_oe;
            dev_clk = 1'b1;
            if (k == 11) dev_data = 1'b1;
            if (glitch_fall == k) begin
                repeat (10) @(negedge clk);
                glitch = 1'b1;
                @(negedge clk);
                glitch = 1'b0;
                repeat (9) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit do_ack,
                             input logic [9:0] exp_bits, output logic [9:0] bits);
        int inh0, rts0, rel0, done0;
        inh0  = inh_cnt;
        rts0  = rts_cnt;
        rel0  = rel_cnt;
        done0 = done_cnt;
        send_byte(b);
        wait_release(tag, rel0);
        dev_frame(11, do_ack, 0, bits);
        for (int i = 0; i < 200 && done_cnt == done0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check_eq({tag, "_inhibit_len"}, 32'(inh_cnt - inh0), 32'd20);
        check_eq({tag, "_rts_len"},     32'(rts_cnt - rts0), 32'd1);
        check_eq({tag, "_done_pulses"}, 32'(done_cnt - done0), 32'd1);
        check_eq({tag, "_bits"},        32'(bits), 32'(exp_bits));
    endtask

    initial begin
        logic [9:0] bits;
        int done0, rel0, inh0, rts0;

        // Reset state
        repeat (5) @(negedge clk);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_busy",     32'(busy), 32'd0);
        check_eq("rst_oe",       32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check_eq("rst_done",     32'({done, ack_ok, err}), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Set-LEDs command, acknowledged: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
        run_frame("ed", ps2_pkg::CMD_SET_LEDS, 1'b1, 10'h3ED, bits);
        check_eq("ed_ack_ok", 32'(last_ack), 32'd1);
        check_eq("ed_err",    32'(last_err), 32'd0);
        check_eq("ed_busy_after", 32'(busy), 32'd0);
        check_eq("ed_oe_after", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        repeat (10) @(negedge clk);

        // 0x01: one set bit, parity 0 so data is pulled at the 9th fall
        run_frame("b01", 8'h01, 1'b1, 10'h201, bits);
        check_eq("b01_parity", 32'(bits[8]), 32'd0);
        check_eq("b01_ack_ok", 32'(last_ack), 32'd1);
        repeat (10) @(negedge clk);

        // 0x00: parity 1
        run_frame("b00", 8'h00, 1'b1, 10'h300, bits);
        check_eq("b00_parity", 32'(bits[8]), 32'd1);
        repeat (10) @(negedge clk);

        // Device never clocks: err exactly 200 cycles after release
        done0 = done_cnt;
        rel0  = rel_cnt;
        send_byte(8'hED);
        wait_release("tmo", rel0);
        for (int i = 0; i < 400 && done_cnt == done0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_eq("tmo_done_pulses", 32'(done_cnt - done0), 32'd1);
        check_eq("tmo_latency",     32'(done_cyc - rel_cyc), 32'd200);
        check_eq("tmo_err",         32'(last_err), 32'd1);
        check_eq("tmo_ack_ok",      32'(last_ack), 32'd0);
        check_eq("tmo_oe",          32'(oe_at_done), 32'd0);
        repeat (10) @(negedge clk);

        // No acknowledge: data stays high at the 11th fall
        run_frame("nack", ps2_pkg::CMD_ENABLE, 1'b0, 10'h2F4, bits);
        check_eq("nack_ack_ok", 32'(last_ack), 32'd0);
        check_eq("nack_err",    32'(last_err), 32'd1);
        repeat (10) @(negedge clk);

        // Reset after the 4th fall of 0xFF aborts the frame immediately
        done0 = done_cnt;
        rel0  = rel_cnt;
        send_byte(ps2_pkg::CMD_RESET);
        wait_release("abort", rel0);
        dev_frame(4, 1'b0, 0, bits);
        check_eq("abort_busy_before", 32'(busy), 32'd1);
        check_eq("abort_bits_low",    32'(bits[3:0]), 32'hF);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_oe",       32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check_eq("abort_tx_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt - done0), 32'd0);

        run_frame("f4", ps2_pkg::CMD_ENABLE, 1'b1, 10'h2F4, bits);
        check_eq("f4_ack_ok", 32'(last_ack), 32'd1);
        check_eq("f4_err",    32'(last_err), 32'd0);
        repeat (10) @(negedge clk);

        // Glitch on ps2_clk during SEND, tx_valid held for the whole frame
        done0 = done_cnt;
        rel0  = rel_cnt;
        rts0  = rts_cnt;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        fork
            begin
                wait_release("glitch", rel0);
                dev_frame(11, 1'b1, 3, bits);
            end
            begin
                for (int i = 0; i < 800 && !done; i++) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        inh0 = inh_cnt;
        repeat (60) @(negedge clk);
        check_eq("glitch_bits",        32'(bits), 32'h3A5);
        check_eq("glitch_done_pulses", 32'(done_cnt - done0), 32'd1);
        check_eq("glitch_ack_ok",      32'(last_ack), 32'd1);
        check_eq("glitch_one_frame",   32'(rts_cnt - rts0), 32'd1);
        check_eq("glitch_no_refire",   32'(inh_cnt - inh0), 32'd0);
        check_eq("glitch_idle",        32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the opposite direction of the keyboard receive path on the same ps2_clk/data pair.
- Sends one command byte to the keyboard, e.g. 8'hED (set LEDs) plus argument, or 8'hFF (reset).
- Implements inhibit, request-to-send, device-clocked bit shifting and the device acknowledge bit.
- Drives the lines only through open-drain enables. Tells the receiver to ignore the bus while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
- FIRST_EDGE_TIMEOUT, 750000: max clk cycles from clock release to the first device falling edge (15 ms).
- BIT_TIMEOUT, 10000: max clk cycles between consecutive device falling edges, and the max wait for bus idle after ack (200 us).
- FILTER_LEN, 4: consecutive equal synchronized samples needed to accept a new ps2_clk level.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ps2_clk_in  in  1  raw PS/2 clock line level (asynchronous)
- ps2_data_in  in  1  raw PS/2 data line level (asynchronous)
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release
- ps2_data_oe  out  1  1 = pull data low, 0 = release
- tx_data  in  8  byte to send
- tx_valid  in  1  request; tx_data is taken in the cycle tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE; the receiver gates its frame capture with this
- done  out  1  one-cycle pulse at the end of every transfer attempt
- ack_ok  out  1  valid with done: 1 = device acknowledged (data low at the 11th edge)
- err  out  1  valid with done: 1 = timeout or missing ack

Behaviour:
- Reset: FSM = IDLE; ps2_clk_oe = ps2_data_oe = 0; tx_ready = 1; busy, done, ack_ok and err = 0; all counters = 0; synchronizer and filter state = 1 (idle bus).
- Both input lines pass through 2-FF synchronizers. ps2_clk is also filtered; fall = one-cycle pulse on a filtered 1->0 transition. The latency from line change to fall is 2 + FILTER_LEN cycles.
- On accept, shift register = {1'b1 stop, odd parity = ~^tx_data, tx_data}: 10 bits, sent LSB first.
- IDLE: on tx_valid, latch the shift register and go to INHIBIT.
- INHIBIT: clk_oe = 1 and data_oe = 0 for INHIBIT_CYCLES cycles, then go to RTS.
- RTS: clk_oe = 1 and data_oe = 1 (start bit) for exactly 1 cycle, then go to SEND. From here clk_oe = 0.
- SEND: the edge counter starts at 0.
  - On each fall with count 0..9, drive shift[count]: data_oe = ~bit; the stop bit releases data. Increment the counter.
  - data_oe keeps the start-bit value (1) until the first fall.
  - The timer clears on each fall. Timeout limit is FIRST_EDGE_TIMEOUT before the first fall, BIT_TIMEOUT after it. Timeout sends the FSM to ERR.
  - After the 10th fall (stop bit driven) go to ACK.
- ACK: data_oe = 0. On the next fall, sample synced data: 0 sets ack_flag = 1, 1 sets ack_flag = 0. Go to WAIT_IDLE. Timeout (BIT_TIMEOUT) goes to ERR.
- WAIT_IDLE: wait until filtered clk = 1 and synced data = 1, then go to DONE. If this takes longer than BIT_TIMEOUT, go to ERR.
- DONE: 1 cycle with done = 1, ack_ok = ack_flag, err = ~ack_flag. Then IDLE.
- ERR: release both lines; done = 1, ack_ok = 0, err = 1 for 1 cycle. Then IDLE.
- tx_valid outside IDLE is ignored; there is no queue, and the caller holds tx_valid until tx_ready.
- rst mid-frame returns to IDLE and releases both lines in the same clock edge. The device then sees an aborted frame; that is acceptable.
- A fall during IDLE or INHIBIT is ignored.
- Simultaneous fall and timer expiry: fall wins.
- Counters are sized with $clog2 of their limit. The timeout compare is >=; the timer saturates and never wraps.

Decomposition:
- ps2_pkg: state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE, ERR); constants CMD_SET_LEDS 8'hED, CMD_RESET 8'hFF, CMD_ENABLE 8'hF4, RESP_ACK 8'hFA, FRAME_TX_BITS 10.
- Sub-module ps2_line_sync: 2-FF sync, FILTER_LEN glitch filter and falling-edge pulse. It is instantiated for ps2_clk; data uses the sync stage only. The same sub-module is reusable by the receive path.

Test Plan (INHIBIT_CYCLES = 20, FIRST_EDGE_TIMEOUT = 200, BIT_TIMEOUT = 100; device model toggles ps2_clk with a 40-cycle period):
- tx_data = 8'hED, model acks -> clk_oe high 20 cycles, then 1 cycle of data_oe; after release, bits at falls 1..10 are 1,0,1,1,0,1,1,1, parity 1, stop 1; done with ack_ok = 1, err = 0; busy low afterwards.
- tx_data = 8'h01 -> parity bit 0 (data_oe = 1 at the 9th fall); tx_data = 8'h00 -> parity 1.
- Model never clocks -> err pulse exactly 200 cycles after clock release; both oe = 0.
- Model keeps data high at the 11th fall -> done = 1, ack_ok = 0, err = 1.
- rst asserted after the 4th fall of 8'hFF -> next cycle oe = 0, tx_ready = 1. A new 8'hF4 then completes with ack_ok = 1.
- 1-cycle glitch on ps2_clk during SEND -> no extra bit consumed; frame still correct; tx_valid held during busy -> exactly one frame sent.
